voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer.sv | 160 ++++++++++++++++
 tb/tb_voice_mixer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// Four-voice audio mixer: sums one sample per voice each lrclk frame, applies master
// gain (128 = unity), saturates to 16 bits and presents the result on LDATA/RDATA.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int GAIN_W     = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    lrclk,
  input  logic signed [15:0]      voice0,
  input  logic signed [15:0]      voice1,
  input  logic signed [15:0]      voice2,
  input  logic signed [15:0]      voice3,
  input  logic [GAIN_W-1:0]       gain,
  input  logic                    mute,
  output logic signed [15:0]      LDATA,
  output logic signed [15:0]      RDATA,
  output logic                    sample_valid,
  output logic                    clip,
  output logic                    overrun,
  output logic                    busy
);

  localparam int ACC_W  = 18;
  localparam int PROD_W = ACC_W + GAIN_W + 1;
  localparam int SCL_W  = PROD_W - 7;
  localparam logic signed [SCL_W-1:0] MAX_S = SCL_W'(32767);
  localparam logic signed [SCL_W-1:0] MIN_S = -SCL_W'(32768);

  typedef enum logic [2:0] {IDLE, ACC, SCALE, SAT, OUT} state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]                idx_q, idx_d;
  logic signed [SCL_W-1:0]   scaled_q, scaled_d;
  logic                      mute_q, mute_d;
  logic signed [15:0]        data_q, data_d;
  logic                      clip_q, clip_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      busy_q, busy_d;
  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic                      edge_q, edge_d;

  logic                      frame_start;
  logic signed [15:0]        voice_sel;
  logic signed [PROD_W-1:0]  prod;

  assign frame_start = sync2_q & ~edge_q;
  assign prod = PROD_W'(acc_q) * PROD_W'($signed({1'b0, gain}));

  always_comb begin
    case (idx_q)
      2'd0:    voice_sel = voice0;
      2'd1:    voice_sel = voice1;
      2'd2:    voice_sel = voice2;
      default: voice_sel = voice3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    scaled_d  = scaled_q;
    mute_d    = mute_q;
    data_d    = data_q;
    clip_d    = clip_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    sync1_d   = lrclk;
    sync2_d   = sync1_q;
    edge_d    = sync2_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ACC;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ACC: begin
        acc_d = acc_q + {{(ACC_W-16){voice_sel[15]}}, voice_sel};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(NUM_VOICES - 1)) state_d = SCALE;
      end
      SCALE: begin
        // Dropping the low 7 product bits is the arithmetic shift by 7 (floor).
        scaled_d = prod[PROD_W-1:7];
        mute_d   = mute;
        state_d  = SAT;
      end
      SAT: begin
        // Output registers load here so the new sample is visible during OUT.
        valid_d = 1'b1;
        state_d = OUT;
        if (mute_q) begin
          data_d = '0;
          clip_d = 1'b0;
        end else if (scaled_q > MAX_S) begin
          data_d = 16'sh7FFF;
          clip_d = 1'b1;
        end else if (scaled_q < MIN_S) begin
          data_d = 16'sh8000;
          clip_d = 1'b1;
        end else begin
          data_d = scaled_q[15:0];
          clip_d = 1'b0;
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (frame_start && (state_q != IDLE)) overrun_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      scaled_q  <= '0;
      mute_q    <= 1'b0;
      data_q    <= '0;
      clip_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      scaled_q  <= scaled_d;
      mute_q    <= mute_d;
      data_q    <= data_d;
      clip_q    <= clip_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      edge_q    <= edge_d;
    end
  end

  assign LDATA        = data_q;
  assign RDATA        = data_q;
  assign sample_valid = valid_q;
  assign clip         = clip_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed and randomized frames for voice_mixer, checked against an arithmetic
// model of sum * gain / 128 (floor), clamped to 16 bits.
module tb_voice_mixer;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b1;
  logic               lrclk = 1'b0;
  logic signed [15:0] voice0 = '0, voice1 = '0, voice2 = '0, voice3 = '0;
  logic [7:0]         gain = 8'd128;
  logic               mute = 1'b0;
  logic signed [15:0] LDATA, RDATA;
  logic               sample_valid, clip, overrun, busy;

  int vectors = 0;
  int miscompares = 0;

  logic signed [15:0] vv [4];
  logic [7:0]         gg;
  logic               mm;
  int                 exp_data, exp_clip;

  voice_mixer #(.NUM_VOICES(4), .GAIN_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .lrclk(lrclk),
    .voice0(voice0), .voice1(voice1), .voice2(voice2), .voice3(voice3),
    .gain(gain), .mute(mute),
    .LDATA(LDATA), .RDATA(RDATA), .sample_valid(sample_valid),
    .clip(clip), .overrun(overrun), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model();
    int sum, p, q;
    sum = int'(vv[0]) + int'(vv[1]) + int'(vv[2]) + int'(vv[3]);
    p = sum * int'(gg);
    q = p / 128;
    if (p < 0 && (p % 128) != 0) q = q - 1;
    if (mm) begin
      exp_data = 0; exp_clip = 0;
    end else if (q > 32767) begin
      exp_data = 32767; exp_clip = 1;
    end else if (q < -32768) begin
      exp_data = -32768; exp_clip = 1;
    end else begin
      exp_data = q; exp_clip = 0;
    end
  endfunction

  task automatic set_voices(input int a, input int b, input int c, input int d,
                            input int g, input int m);
    vv[0] = 16'(a); vv[1] = 16'(b); vv[2] = 16'(c); vv[3] = 16'(d);
    gg = 8'(g); mm = 1'(m);
  endtask

  task automatic rand_voices();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 0) vv[i] = 16'($signed($urandom_range(0, 8000)) - 4000);
      else vv[i] = 16'($urandom);
    end
    gg = 8'($urandom);
    mm = ($urandom_range(0, 5) == 0);
  endtask

  task automatic scramble_inputs();
    voice0 = 16'($urandom); voice1 = 16'($urandom);
    voice2 = 16'($urandom); voice3 = 16'($urandom);
  endtask

  task automatic drive_vals();
    voice0 = vv[0]; voice1 = vv[1]; voice2 = vv[2]; voice3 = vv[3];
    gain = gg; mute = mm;
  endtask

  task automatic wait_busy(output int ok);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  // n counts negedges after the first one with busy high; inputs are disturbed
  // once the four ACC reads are done (voices) and after SCALE (gain/mute).
  task automatic wait_valid(output int n);
    n = 0;
    while (!sample_valid && n < 15) begin
      @(negedge Clk);
      n++;
      if (n == 4) scramble_inputs();
      if (n == 5) begin
        gain = ~gain;
        mute = ~mute;
      end
    end
  endtask

  task automatic do_frame(input string tag);
    int ok, n;
    @(negedge Clk);
    drive_vals();
    model();
    #2 lrclk = 1'b1;
    wait_busy(ok);
    chk({tag, " start"}, ok, 1);
    if (ok == 1) begin
      wait_valid(n);
      chk({tag, " latency"}, n, 6);
      chk({tag, " LDATA"}, LDATA, exp_data);
      chk({tag, " RDATA"}, RDATA, exp_data);
      chk({tag, " clip"}, clip, exp_clip);
      chk({tag, " busy_out"}, busy, 1);
      @(negedge Clk);
      chk({tag, " valid_pulse"}, sample_valid, 0);
      chk({tag, " busy_idle"}, busy, 0);
    end
    lrclk = 1'b0;
    repeat (4) @(negedge Clk);
    scramble_inputs();
    @(negedge Clk);
    chk({tag, " hold_data"}, LDATA, exp_data);
    chk({tag, " hold_clip"}, clip, exp_clip);
  endtask

  initial begin
    int ok, n, pulses, cap;

    #1 Reset_n = 1'b0;
    #1;
    chk("rst LDATA", LDATA, 0);
    chk("rst RDATA", RDATA, 0);
    chk("rst valid", sample_valid, 0);
    chk("rst clip", clip, 0);
    chk("rst overrun", overrun, 0);
    chk("rst busy", busy, 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    set_voices(1000, 2000, 3000, 4000, 128, 0);      do_frame("basic");
    chk("basic model", exp_data, 10000);
    set_voices(16000, 16000, 16000, 16000, 128, 0);  do_frame("sat_hi");
    set_voices(0, 0, 0, 0, 128, 0);                  do_frame("zero");
    set_voices(-20000, -20000, -20000, -20000, 255, 0); do_frame("sat_lo");
    set_voices(100, 100, 100, 100, 64, 0);           do_frame("half");
    set_voices(100, 100, 100, 100, 64, 1);           do_frame("mute");
    set_voices(-30000, 30000, -12345, 32767, 0, 0);  do_frame("gain0");
    set_voices(-1, 0, 0, 0, 1, 0);                   do_frame("floor");
    for (int i = 0; i < 20; i++) begin
      rand_voices();
      do_frame("random");
    end
    chk("no overrun yet", overrun, 0);

    // lrclk pulse much shorter than a frame: second edge lands during ACC.
    set_voices(500, -250, 125, 1000, 200, 0);
    @(negedge Clk);
    drive_vals();
    model();
    #2 lrclk = 1'b1;
    wait_busy(ok);
    chk("ovr start", ok, 1);
    lrclk = 1'b0;
    @(negedge Clk);
    lrclk = 1'b1;
    pulses = 0;
    cap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (sample_valid) begin
        pulses++;
        cap = LDATA;
      end
    end
    chk("ovr pulses", pulses, 1);
    chk("ovr data", cap, exp_data);
    chk("ovr flag", overrun, 1);
    chk("ovr busy", busy, 0);
    lrclk = 1'b0;
    repeat (4) @(negedge Clk);
    set_voices(1000, 2000, 3000, 4000, 128, 0);
    do_frame("after_ovr");
    chk("ovr sticky", overrun, 1);

    // Reset during SCALE, then release with lrclk still high.
    set_voices(-7000, 3000, 9000, 1500, 150, 0);
    @(negedge Clk);
    drive_vals();
    #2 lrclk = 1'b1;
    wait_busy(ok);
    chk("rst_mid start", ok, 1);
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("rst_mid LDATA", LDATA, 0);
    chk("rst_mid RDATA", RDATA, 0);
    chk("rst_mid clip", clip, 0);
    chk("rst_mid overrun", overrun, 0);
    chk("rst_mid busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (sample_valid) pulses++;
    end
    chk("rst_mid no_valid", pulses, 0);
    set_voices(2500, -1200, 800, 4000, 100, 0);
    drive_vals();
    model();
    Reset_n = 1'b1;
    wait_busy(ok);
    chk("rst_rel start", ok, 1);
    if (ok == 1) begin
      wait_valid(n);
      chk("rst_rel latency", n, 6);
      chk("rst_rel LDATA", LDATA, exp_data);
      chk("rst_rel clip", clip, exp_clip);
    end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clk);
      if (sample_valid) pulses++;
    end
    chk("rst_rel single", pulses, 0);
    chk("rst_rel overrun", overrun, 0);
    lrclk = 1'b0;
    repeat (4) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
